pc_seq_ctrl: RTL

- Fetch-stage PC sequencer for the 5-stage MIPS pipeline.
- Owns the PC register. Each cycle it selects sequential, branch/jump-redirect or held PC.
- Computes beq/bne/j/jal/jr targets from decode-stage operands and honours the architectural delay slot.
- Latches a redirect that arrives while instruction memory is not ready, then keeps branch/taken performance counters.

---
 rtl/pc_seq_ctrl_if.sv | 34 +++
 rtl/pc_seq_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl_if.sv
// Fetch-side bundle of the PC sequencer: decode-stage branch operands in,
// fetch PC, event pulses and performance counters out.
interface pc_seq_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             imem_ready;
    logic             br_valid;
    logic [2:0]       br_type;
    logic             cmp_eq;
    logic [31:0]      imm_ext;
    logic [25:0]      instr_index;
    logic [31:0]      rs_val;
    logic [31:0]      pc4_d;
    logic [31:0]      pc_f;
    logic [31:0]      pc4_f;
    logic             redirect;
    logic             pend_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, imem_ready, br_valid, br_type, cmp_eq, imm_ext, instr_index, rs_val,
               pc4_d,
        input  pc_f, pc4_f, redirect, pend_valid, misalign_err, br_cnt, taken_cnt
    );

    modport slave (
        input  stall, imem_ready, br_valid, br_type, cmp_eq, imm_ext, instr_index, rs_val,
               pc4_d,
        output pc_f, pc4_f, redirect, pend_valid, misalign_err, br_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage PC sequencer: sequential / branch / jump / jr redirect with delay slot,
// deferral of a taken target while imem stalls, and branch/taken counters.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    pc_seq_ctrl_if.slave    bus
);

    typedef enum logic {StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_f_q, pc_f_d;
    logic [31:0]      pend_target_q, pend_target_d;
    logic             pend_valid_q, pend_valid_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [31:0] target;
    logic [31:0] pc4_f;
    logic        cond;
    logic        legal;
    logic        is_jr;
    logic        advance;
    logic        taken;

    assign pc4_f = pc_f_q + 32'd4;

    always_comb begin
        target = pc4_d_plus_zero();
        cond   = 1'b0;
        legal  = 1'b0;
        is_jr  = 1'b0;
        unique case (bus.br_type)
            3'b001: begin
                target = bus.pc4_d + (bus.imm_ext << 2);
                cond   = bus.cmp_eq;
                legal  = 1'b1;
            end
            3'b010: begin
                target = bus.pc4_d + (bus.imm_ext << 2);
                cond   = !bus.cmp_eq;
                legal  = 1'b1;
            end
            3'b011: begin
                target = {bus.pc4_d[31:28], bus.instr_index, 2'b00};
                cond   = 1'b1;
                legal  = 1'b1;
            end
            3'b100: begin
                target = {bus.rs_val[31:2], 2'b00};
                cond   = 1'b1;
                legal  = 1'b1;
                is_jr  = 1'b1;
            end
            default: ;
        endcase
    end

    // D cannot advance while a redirect is pending, so br_valid is ignored there.
    assign advance = bus.br_valid && !bus.stall && (state_q == StRun);
    assign taken   = advance && cond;

    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        redirect_d    = 1'b0;
        misalign_d    = taken && is_jr && (bus.rs_val[1:0] != 2'b00);
        br_cnt_d      = (advance && legal) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        taken_cnt_d   = taken ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;

        if (!bus.stall) begin
            unique case (state_q)
                StRun: begin
                    if (bus.imem_ready) begin
                        pc_f_d     = taken ? target : pc4_f;
                        redirect_d = taken;
                    end else if (taken) begin
                        pend_target_d = target;
                        pend_valid_d  = 1'b1;
                        state_d       = StPend;
                    end
                end
                StPend: begin
                    if (bus.imem_ready) begin
                        pc_f_d       = pend_target_q;
                        redirect_d   = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            pc_f_q        <= RESET_PC;
            pend_target_q <= 32'h0;
            pend_valid_q  <= 1'b0;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            redirect_q    <= redirect_d;
            misalign_q    <= misalign_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    function automatic logic [31:0] pc4_d_plus_zero();
        return bus.pc4_d;
    endfunction

    assign bus.pc_f         = pc_f_q;
    assign bus.pc4_f        = pc4_f;
    assign bus.redirect     = redirect_q;
    assign bus.pend_valid   = pend_valid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.br_cnt       = br_cnt_q;
    assign bus.taken_cnt    = taken_cnt_q;

endmodule
